// File: rtl/debounce_pkg.sv
// Shared FSM state encoding, default parameters and saturating counter helpers
// for the button debouncer.
package debounce_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_PEND = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_REL_PEND   = 2'd3;

  localparam int         DEF_NBTN           = 4;
  localparam int         DEF_STABLE_SAMPLES = 3;
  localparam int         DEF_REPEAT_DELAY   = 8;
  localparam int         DEF_REPEAT_RATE    = 3;
  localparam logic [3:0] DEF_REPEAT_MASK    = 4'b0011;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [7:0] sat_dec8(input logic [7:0] v);
    return (v == 8'd0) ? v : v - 8'd1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: IDLE/PRESS_PEND/HELD/REL_PEND FSM plus auto-repeat counter.
// Pulses appear one clk after the deciding sample_en cycle; no backpressure.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE    = DEF_REPEAT_RATE,
  parameter bit REPEAT_EN      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic sample,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_SAMPLES);
  localparam logic [7:0] DELAY_N  = 8'(REPEAT_DELAY);
  localparam logic [7:0] RATE_N   = 8'(REPEAT_RATE);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rep_cnt_q, rep_cnt_d;
  logic       press_q, press_d;
  logic       rel_q, rel_d;
  logic [3:0] cnt_inc;
  logic [7:0] rep_dec;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rep_cnt_d = rep_cnt_q;
    press_d   = 1'b0;
    rel_d     = 1'b0;
    cnt_inc   = sat_inc4(cnt_q);
    rep_dec   = sat_dec8(rep_cnt_q);
    if (sample_en) begin
      case (state_q)
        ST_IDLE: begin
          if (sample) begin
            if (STABLE_N == 4'd1) begin
              state_d   = ST_HELD;
              cnt_d     = 4'd0;
              rep_cnt_d = DELAY_N;
              press_d   = 1'b1;
            end else begin
              state_d = ST_PRESS_PEND;
              cnt_d   = 4'd1;
            end
          end
        end
        ST_PRESS_PEND: begin
          if (!sample) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end else if (cnt_inc >= STABLE_N) begin
            state_d   = ST_HELD;
            cnt_d     = 4'd0;
            rep_cnt_d = DELAY_N;
            press_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_HELD: begin
          if (!sample) begin
            if (STABLE_N == 4'd1) begin
              state_d = ST_IDLE;
              rel_d   = 1'b1;
            end else begin
              state_d = ST_REL_PEND;
              cnt_d   = 4'd1;
            end
          end else if (REPEAT_EN) begin
            // Reaching zero fires a repeat and rearms at the faster rate.
            if (rep_dec == 8'd0) begin
              press_d   = 1'b1;
              rep_cnt_d = RATE_N;
            end else begin
              rep_cnt_d = rep_dec;
            end
          end
        end
        default: begin
          if (sample) begin
            state_d = ST_HELD;
            cnt_d   = 4'd0;
          end else if (cnt_inc >= STABLE_N) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      rep_cnt_q <= 8'd0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rep_cnt_q <= rep_cnt_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
    end
  end

  assign level         = (state_q == ST_HELD) || (state_q == ST_REL_PEND);
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

endmodule

// File: rtl/btn_debouncer.sv
// Multi-channel button debouncer with auto-repeat; shared tick sync/edge detect.
// sample_en lags the db_tick pin edge by 3 clk, events by one more; no backpressure.
module btn_debouncer
  import debounce_pkg::*;
#(
  parameter int              NBTN           = DEF_NBTN,
  parameter int              STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int              REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int              REPEAT_RATE    = DEF_REPEAT_RATE,
  parameter logic [NBTN-1:0] REPEAT_MASK    = NBTN'(DEF_REPEAT_MASK)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            db_tick,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release
);

  logic            tick_s1_q, tick_s1_d;
  logic            tick_s2_q, tick_s2_d;
  logic            tick_prev_q, tick_prev_d;
  logic            sample_en_q, sample_en_d;
  logic [NBTN-1:0] btn_s1_q, btn_s1_d;
  logic [NBTN-1:0] btn_s2_q, btn_s2_d;

  always_comb begin
    tick_s1_d   = db_tick;
    tick_s2_d   = tick_s1_q;
    tick_prev_d = tick_s2_q;
    sample_en_d = tick_s2_q & ~tick_prev_q;
    btn_s1_d    = btn_raw;
    btn_s2_d    = btn_s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_s1_q   <= 1'b0;
      tick_s2_q   <= 1'b0;
      tick_prev_q <= 1'b0;
      sample_en_q <= 1'b0;
      btn_s1_q    <= '0;
      btn_s2_q    <= '0;
    end else begin
      tick_s1_q   <= tick_s1_d;
      tick_s2_q   <= tick_s2_d;
      tick_prev_q <= tick_prev_d;
      sample_en_q <= sample_en_d;
      btn_s1_q    <= btn_s1_d;
      btn_s2_q    <= btn_s2_d;
    end
  end

  for (genvar i = 0; i < NBTN; i++) begin : g_chan
    debounce_chan #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE),
      .REPEAT_EN     (REPEAT_MASK[i])
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .sample_en    (sample_en_q),
      .sample       (btn_s2_q[i]),
      .level        (btn_level[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench: each tick pushes its expected press/release event (with the cycle it
// must appear in) to a scoreboard; a monitor compares every cycle against it.
module tb_btn_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic       db_tick;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic [3:0] r;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  btn_debouncer dut (
    .clk        (clk),
    .rst        (rst),
    .db_tick    (db_tick),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle: either a scheduled event must appear exactly now, or nothing may.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        checks++;
        assert (btn_press === e.p) else begin
          errors++;
          $error("FAIL press@%0d: got %b expected %b", cyc, btn_press, e.p);
        end
        checks++;
        assert (btn_release === e.r) else begin
          errors++;
          $error("FAIL release@%0d: got %b expected %b", cyc, btn_release, e.r);
        end
      end else begin
        checks++;
        assert ({btn_press, btn_release} === 8'h00) else begin
          errors++;
          $error("FAIL idle@%0d: got press=%b release=%b expected 0000/0000",
                 cyc, btn_press, btn_release);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One 8-cycle debounce tick; called right after a negedge. The event lands 4 cycles later.
  task automatic tick(input logic [3:0] raw, input logic [3:0] ep, input logic [3:0] er,
                      input logic [3:0] el, input string tag);
    exp_t x;
    btn_raw = raw;
    db_tick = 1'b1;
    if (ep != 4'd0 || er != 4'd0) begin
      x.cyc = cyc + 4;
      x.p   = ep;
      x.r   = er;
      sb_q.push_back(x);
    end
    repeat (4) @(negedge clk);
    db_tick = 1'b0;
    btn_raw = ~raw;
    repeat (2) @(negedge clk);
    btn_raw = raw;
    @(negedge clk);
    chk({tag, " level"}, btn_level, el);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] ep;
    logic [3:0] el;
    logic [4:0] bounce;
    rst     = 1'b1;
    db_tick = 1'b0;
    btn_raw = 4'd0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("rst level", btn_level, 4'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst level", btn_level, 4'd0);

    // Clean press on channel 0 then auto-repeat at delay 8, rate 3.
    for (int t = 1; t <= 20; t++) begin
      ep = (t == 3 || t == 11 || t == 14 || t == 17 || t == 20) ? 4'b0001 : 4'b0000;
      el = (t >= 3) ? 4'b0001 : 4'b0000;
      tick(4'b0001, ep, 4'b0000, el, $sformatf("rep t%0d", t));
    end
    tick(4'b0000, 4'b0000, 4'b0000, 4'b0001, "rel0 t1");
    tick(4'b0000, 4'b0000, 4'b0000, 4'b0001, "rel0 t2");
    tick(4'b0000, 4'b0000, 4'b0001, 4'b0000, "rel0 t3");

    // Bounce on channel 1: samples 1,0,1,1,1.
    bounce = 5'b11101;
    for (int t = 0; t < 5; t++) begin
      tick({2'b00, bounce[t], 1'b0}, (t == 4) ? 4'b0010 : 4'b0000, 4'b0000,
           (t == 4) ? 4'b0010 : 4'b0000, $sformatf("bounce t%0d", t + 1));
    end
    tick(4'b0000, 4'b0000, 4'b0000, 4'b0010, "rel1 t1");
    tick(4'b0000, 4'b0000, 4'b0000, 4'b0010, "rel1 t2");
    tick(4'b0000, 4'b0000, 4'b0010, 4'b0000, "rel1 t3");

    // Channel 2 has repeat disabled.
    for (int t = 1; t <= 20; t++) begin
      tick(4'b0100, (t == 3) ? 4'b0100 : 4'b0000, 4'b0000,
           (t >= 3) ? 4'b0100 : 4'b0000, $sformatf("norep t%0d", t));
    end
    tick(4'b0000, 4'b0000, 4'b0000, 4'b0100, "rel2 t1");
    tick(4'b0000, 4'b0000, 4'b0000, 4'b0100, "rel2 t2");
    tick(4'b0000, 4'b0000, 4'b0100, 4'b0000, "rel2 t3");

    // Simultaneous press on channels 0 and 3, then reset while held.
    tick(4'b1001, 4'b0000, 4'b0000, 4'b0000, "sim t1");
    tick(4'b1001, 4'b0000, 4'b0000, 4'b0000, "sim t2");
    tick(4'b1001, 4'b1001, 4'b0000, 4'b1001, "sim t3");
    rst = 1'b1;
    @(negedge clk);
    chk("midrst level", btn_level, 4'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst+1 level", btn_level, 4'd0);

    // Re-press needs three fresh samples; a one-sample release dip keeps the repeat count.
    tick(4'b1001, 4'b0000, 4'b0000, 4'b0000, "re t1");
    tick(4'b1001, 4'b0000, 4'b0000, 4'b0000, "re t2");
    tick(4'b1001, 4'b1001, 4'b0000, 4'b1001, "re t3");
    tick(4'b1001, 4'b0000, 4'b0000, 4'b1001, "re t4");
    tick(4'b1001, 4'b0000, 4'b0000, 4'b1001, "re t5");
    tick(4'b0000, 4'b0000, 4'b0000, 4'b1001, "dip t6");
    tick(4'b1001, 4'b0000, 4'b0000, 4'b1001, "dip t7");
    for (int t = 8; t <= 13; t++) begin
      tick(4'b1001, (t == 13) ? 4'b0001 : 4'b0000, 4'b0000, 4'b1001,
           $sformatf("dip t%0d", t));
    end
    tick(4'b0000, 4'b0000, 4'b0000, 4'b1001, "rel03 t1");
    tick(4'b0000, 4'b0000, 4'b0000, 4'b1001, "rel03 t2");
    tick(4'b0000, 4'b0000, 4'b1001, 4'b0000, "rel03 t3");

    repeat (4) @(negedge clk);
    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard: %0d events never seen, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_debouncer.md
BTN_DEBOUNCER -- requirements
Module: btn_debouncer

Interface
REQ-001 Parameter NBTN, default 4, number of button channels.
REQ-002 Parameter STABLE_SAMPLES, default 3, consecutive equal samples needed to change debounced state; legal range 1..15.
REQ-003 Parameter REPEAT_DELAY, default 8, sample ticks from a debounced press to the first auto-repeat; legal range 1..255.
REQ-004 Parameter REPEAT_RATE, default 3, sample ticks between later auto-repeats; legal range 1..255.
REQ-005 Parameter REPEAT_MASK, default 4'b0011, per-channel auto-repeat enable; bit i applies to channel i.
REQ-006 clk  input  1  system clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 db_tick  input  1  square-wave debounce-rate clock from the clock divider; asynchronous to clk in phase.
REQ-009 btn_raw  input  NBTN  raw, asynchronous, bouncing button levels, active-high.
REQ-010 btn_level  output  NBTN  debounced level per channel.
REQ-011 btn_press  output  NBTN  one-cycle pulse on a debounced press or an auto-repeat.
REQ-012 btn_release  output  NBTN  one-cycle pulse on a debounced release.

Function
REQ-013 db_tick and each btn_raw bit shall each pass through a 2-flop synchronizer.
REQ-014 A registered rising-edge detector on synchronized db_tick shall produce sample_en, high for exactly one clk cycle, 3 cycles after the db_tick rising edge at the pin.
REQ-015 Each channel shall run a 4-state FSM: IDLE, PRESS_PEND, HELD, REL_PEND; only sample_en cycles advance it.
REQ-016 IDLE: sample 1 -> PRESS_PEND with cnt=1 (when STABLE_SAMPLES=1, go directly to HELD); sample 0 -> stay.
REQ-017 PRESS_PEND: sample 1 -> cnt+1; when cnt reaches STABLE_SAMPLES -> HELD. Sample 0 -> IDLE with cnt=0.
REQ-018 HELD: sample 0 -> REL_PEND with cnt=1 (when STABLE_SAMPLES=1, go directly to IDLE); sample 1 -> stay and run the repeat logic.
REQ-019 REL_PEND: sample 0 -> cnt+1; when cnt reaches STABLE_SAMPLES -> IDLE. Sample 1 -> HELD with cnt=0; the repeat counter is not reloaded.
REQ-020 btn_level shall be 1 exactly in HELD and REL_PEND.
REQ-021 btn_press shall pulse in the cycle after the sample_en cycle that enters HELD from PRESS_PEND or IDLE.
REQ-022 btn_release shall pulse in the cycle after the sample_en cycle that enters IDLE from REL_PEND or HELD.
REQ-023 On entering HELD from a press, rep_cnt shall load REPEAT_DELAY.
REQ-024 While in HELD with REPEAT_MASK[i]=1, each sample_en with sample 1 shall decrement rep_cnt. On reaching 0: btn_press pulses in the next cycle and rep_cnt reloads REPEAT_RATE.
REQ-025 With REPEAT_MASK[i]=0, rep_cnt shall be held and no repeat pulse shall occur.
REQ-026 rep_cnt shall be 8 bits and cnt 4 bits, with no wrap: counters saturate at their terminal value.
REQ-027 Channels shall be fully independent; simultaneous events on any set of channels shall all be reported in the same cycle.
REQ-028 Changes on btn_raw between sample_en cycles shall have no effect apart from the value sampled at the next sample_en.

Reset
REQ-029 While rst=1, and in the cycle after rst deasserts:
- every FSM is IDLE; cnt and rep_cnt are 0
- synchronizer and edge flops are 0
- btn_level, btn_press and btn_release are 0
REQ-030 A reset mid-press or mid-repeat shall abort without emitting btn_release.
REQ-031 If db_tick is high when reset releases, the first sample_en shall occur within 3 cycles.

Structure
REQ-032 FSM state encoding and default parameter values shall live in shared package debounce_pkg.
REQ-033 The per-channel FSM and counters shall be sub-module debounce_chan, instantiated NBTN times by a generate loop.
REQ-034 The tick synchronizer and edge detector shall be instantiated once, in btn_debouncer, and shared by all channels.

Verification
REQ-035 Clean press: btn_raw[0]=1 held for 3 sample_en -> btn_press[0] pulses once, one cycle after the 3rd sample_en; btn_level[0]=1.
REQ-036 Bounce: channel 1 samples 1,0,1,1,1 -> exactly one btn_press[1], after the 5th sample.
REQ-037 Auto-repeat: channel 0 held for 20 ticks with defaults -> btn_press pulses after ticks 3, 11, 14, 17 and 20.
REQ-038 No-repeat channel: channel 2 held for 20 ticks -> exactly one btn_press[2]; btn_release[2] after 3 zero samples.
REQ-039 Simultaneous: channels 0 and 3 pressed on the same tick -> btn_press=4'b1001 in a single cycle.
REQ-040 Reset mid-HELD: rst for 1 cycle -> all outputs 0 next cycle; no btn_release; re-press needs 3 fresh samples.
